// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, reset vector and the canonical NOP.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/riscv_fetch_stage_if.sv
// Fetch-stage bundle: control from hazard/EX, instruction-memory port, IF/ID outputs.
interface riscv_fetch_stage_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 8
);
  logic               stall;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [XLEN-1:0]    if_id_pc;
  logic [XLEN-1:0]    if_id_pc4;
  logic [31:0]        if_id_instr;
  logic               if_id_valid;
  logic               misalign_err;
  logic [31:0]        fetch_count;

  // master is the fetch stage; slave is the surrounding pipeline and memory
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
    output misalign_err, fetch_count
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
    input  misalign_err, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 1-cycle latency; hold freezes all fields, flush inserts a NOP bubble
// while keeping the previous pc/pc4 so decode still sees a stable address.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] d_pc,
  input  logic [31:0]     d_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [31:0]     instr,
  output logic            valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      pc4   <= XLEN'(4);
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= d_pc;
      pc4   <= d_pc + XLEN'(4);
      instr <= d_instr;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, IF/ID register and fetch counter.
// 1-cycle fetch latency; stall holds everything, redirect overrides stall and costs one bubble.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              IMEM_AW  = 8
) (
  input logic                 clk,
  input logic                 rst,
  riscv_fetch_stage_if.master bus
);
  logic [XLEN-1:0] pc;
  logic            misalign_q;
  logic [31:0]     fetch_count_q;

  wire advance = !bus.redirect_valid && !bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (!bus.stall) begin
        pc            <= pc + XLEN'(4);
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  // word address wraps with the memory size rather than the full PC range
  assign bus.imem_addr    = pc[IMEM_AW+1:2];
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = fetch_count_q;

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .hold    (!advance),
    .flush   (bus.redirect_valid),
    .d_pc    (pc),
    .d_instr (bus.imem_rdata),
    .pc      (bus.if_id_pc),
    .pc4     (bus.if_id_pc4),
    .instr   (bus.if_id_instr),
    .valid   (bus.if_id_valid)
  );
endmodule

// File: doc/riscv_fetch_stage.md
# riscv_fetch_stage

Instruction-fetch stage of the pipelined RISC-V core. Holds the program counter, addresses the combinational-read instruction memory (`insmem`), and registers the fetched word into the IF/ID pipeline register consumed by decode. Accepts stall from the hazard unit and redirect/flush from the branch-resolving EX stage. Keeps a retired-fetch performance counter.

## Interface

**Parameters**

- `XLEN`, default 32: PC and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, default 8: instruction-memory word-address width.

**Ports**

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `redirect_valid`  in  1  EX: taken branch/jump this cycle.
- `redirect_pc`  in  XLEN  EX: branch/jump target.
- `imem_addr`  out  IMEM_AW  word address, `pc[IMEM_AW+1:2]`, combinational from PC.
- `imem_rdata`  in  32  instruction word, combinational, same cycle.
- `if_id_pc`  out  XLEN  PC of the instruction in IF/ID.
- `if_id_pc4`  out  XLEN  `if_id_pc + 4`.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_valid`  out  1  IF/ID holds a real instruction, not a bubble.
- `misalign_err`  out  1  one-cycle pulse: last redirect target had `[1:0] != 0`.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.

## Operation

- **Reset** (any edge with `rst`=1):
  - `pc` = RESET_PC.
  - `if_id_pc` = 0, `if_id_pc4` = 4.
  - `if_id_instr` = NOP (32'h0000_0013).
  - `if_id_valid` = 0, `misalign_err` = 0, `fetch_count` = 0.
- **Priority per edge:** `rst` > `redirect_valid` > `stall` > normal advance.
- **Normal** (no redirect, no stall):
  - `pc` ← `pc`+4.
  - IF/ID ← {`pc`, `pc`+4, `imem_rdata`, valid=1}.
  - `fetch_count` ← `fetch_count`+1.
- **Stall** (no redirect):
  - `pc`, IF/ID and `fetch_count` are all held.
  - `imem_addr` is unchanged.
- **Redirect** (overrides stall):
  - `pc` ← {`redirect_pc[XLEN-1:2]`, 2'b00}.
  - IF/ID ← bubble: instr = NOP, valid = 0, `if_id_pc`/`if_id_pc4` hold their previous values.
  - `fetch_count` is not incremented.
  - `misalign_err` ← (`redirect_pc[1:0]` != 0) for exactly one cycle; otherwise 0.
- **PC arithmetic:**
  - `pc` is XLEN bits and wraps modulo 2^XLEN.
  - `imem_addr` is truncated to IMEM_AW bits, so memory accesses wrap at 4·2^IMEM_AW bytes.
  - `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- The block has no FSM beyond the PC/valid registers. Effective states:
  - RESET → RUN on the first edge with `rst`=0.
  - RUN ↔ HOLD on `stall`.
  - Any state → BUBBLE for one cycle on redirect.

## Timing

- Fetch latency is 1 cycle: the instruction at `pc` appears in IF/ID after the next rising edge.
- First valid instruction: `if_id_valid`=1 with `if_id_pc`=RESET_PC after the first edge where `rst`=0.
- Redirect penalty is 1 bubble. Redirect at edge N gives IF/ID valid=0 after N. The target instruction is in IF/ID after N+1, provided there is no stall at N+1.
- Redirect and stall in the same cycle: the redirect is taken. If stall stays high after it, the bubble is held and `pc` stays at the target.
- `rst` asserted mid-stream (including during a stall or redirect): all state returns to reset values at that edge, and in-flight redirects are discarded.
- `misalign_err` is registered. It is high only in the cycle after the redirect edge.

## Structure

- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - Default `RESET_PC`.
  - `XLEN`.
- Sub-module `if_id_reg`: the pipeline register with hold (stall) and bubble-insert (flush) controls.
- The PC register, next-PC mux and counter live in `riscv_fetch_stage` itself.

## Test plan

- **Reset and sequential fetch.** Memory words at 0,4,8 are 32'h00500093, 32'h00A00113, 32'h002081B3. Release `rst` → IF/ID shows `if_id_pc` 0,4,8 with those words on consecutive cycles, valid=1, and `fetch_count` reaches 3.
- **Stall.** Assert `stall` for 3 cycles while `if_id_pc`=4 → `if_id_pc` stays 4, `imem_addr`=2 throughout, and `fetch_count` is frozen. After release, the next `if_id_pc`=8.
- **Redirect.** `redirect_valid`=1, `redirect_pc`=32'h40 → next cycle valid=0 and instr=32'h00000013; the following cycle `if_id_pc`=32'h40 with valid=1.
- **Redirect during stall, misaligned target.** `stall`=1, `redirect_pc`=32'h42 → `pc`=32'h40, `misalign_err`=1 for one cycle, bubble in IF/ID.
- **Wrap.** With IMEM_AW=8 and PC=32'h3FC, after one advance `pc`=32'h400 and `imem_addr`=0.
- **Reset mid-redirect.** `rst` and `redirect_valid` in the same cycle → `pc`=RESET_PC and all outputs at reset values.
